// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: magic constants, word-width helper and the
// key-schedule state encoding.
package rc5_pkg;

    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;
    localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
    localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } rc5_state_e;

    // Number of bits needed to express a rotate amount for a word of this width
    function automatic int f_lgw(input int width);
        int r;
        r = 0;
        for (int n = 0; n < 8; n++) begin
            if ((32'sd1 <<< n) < width) begin
                r = n + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rc5_key_mixer_if.sv
// Control, key-load and S-table read bundle between the RC5 key mixer and
// its neighbours (packing stage in front, round datapath behind).
interface rc5_key_mixer_if #(
    parameter int w = 32,
    parameter int t = 26,
    parameter int c = 4
);
    logic                   start;
    logic [w-1:0]           pW;
    logic [w-1:0]           qW;
    logic [c*w-1:0]         l_in;
    logic                   busy;
    logic                   done;
    logic [$clog2(t)-1:0]   rd_addr;
    logic [w-1:0]           rd_data;

    modport master (
        output start, pW, qW, l_in, rd_addr,
        input  busy, done, rd_data
    );

    modport slave (
        input  start, pW, qW, l_in, rd_addr,
        output busy, done, rd_data
    );
endinterface

// File: rtl/rc5_rotl.sv
// Combinational left rotate of a w-bit word by a $clog2(w)-bit amount.
module rc5_rotl #(
    parameter int w = 32
) (
    input  logic [w-1:0]         data,
    input  logic [$clog2(w)-1:0] amt,
    output logic [w-1:0]         result
);
    logic [2*w-1:0] dbl_s;

    // The upper half of the doubled, shifted word is the rotated word
    always_comb begin
        dbl_s  = {data, data} << amt;
        result = dbl_s[2*w-1:w];
    end
endmodule

// File: rtl/rc5_key_mixer.sv
// RC5 key-expansion mixing stage: builds S from P/Q, mixes it with L for
// 3*max(t,c) iterations, then holds S for the round datapath.
module rc5_key_mixer
    import rc5_pkg::*;
#(
    parameter int w = 32,
    parameter int t = 26,
    parameter int c = 4
) (
    input  logic          clk,
    input  logic          rst,
    rc5_key_mixer_if.slave bus
);
    localparam int LGW = f_lgw(w);
    localparam int IW  = $clog2(t);
    localparam int JW  = (c > 1) ? $clog2(c) : 1;
    localparam int N   = 3 * ((t > c) ? t : c);
    localparam int KW  = $clog2(N);

    rc5_state_e      state_r;
    rc5_state_e      state_s;

    logic [w-1:0]    s_mem [t];
    logic [w-1:0]    l_mem [c];
    logic [w-1:0]    p_r;
    logic [w-1:0]    q_r;
    logic [w-1:0]    a_r;
    logic [w-1:0]    b_r;
    logic [IW-1:0]   i_r;
    logic [JW-1:0]   j_r;
    logic [KW-1:0]   k_r;
    logic            busy_r;
    logic            done_r;
    logic [w-1:0]    rd_data_r;

    logic            accept_s;
    logic            last_init_s;
    logic            last_mix_s;
    logic [IW-1:0]   prev_idx_s;
    logic [IW-1:0]   i_next_s;
    logic [JW-1:0]   j_next_s;
    logic [w-1:0]    init_word_s;
    logic [w-1:0]    s_sum_s;
    logic [w-1:0]    a_new_s;
    logic [w-1:0]    ab_sum_s;
    logic [w-1:0]    l_sum_s;
    logic [LGW-1:0]  amt_s;
    logic [w-1:0]    b_new_s;

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.rd_data = rd_data_r;

    rc5_rotl #(.w(w)) u_rotl_a (
        .data   (s_sum_s),
        .amt    (LGW'(3)),
        .result (a_new_s)
    );

    rc5_rotl #(.w(w)) u_rotl_b (
        .data   (l_sum_s),
        .amt    (amt_s),
        .result (b_new_s)
    );

    // Start acceptance, loop-end detection and index wrap (t, c need not be powers of 2)
    always_comb begin
        accept_s    = bus.start && ((state_r == IDLE) || (state_r == DONE));
        last_init_s = (i_r == IW'(t - 1));
        last_mix_s  = (k_r == KW'(N - 1));
        if (i_r == IW'(t - 1)) begin
            i_next_s = '0;
        end else begin
            i_next_s = i_r + IW'(1);
        end
        if (j_r == JW'(c - 1)) begin
            j_next_s = '0;
        end else begin
            j_next_s = j_r + JW'(1);
        end
        if (i_r == '0) begin
            prev_idx_s = '0;
        end else begin
            prev_idx_s = i_r - IW'(1);
        end
    end

    // INIT word: S[0] = P, otherwise the previous word plus Q
    always_comb begin
        if (i_r == '0) begin
            init_word_s = p_r;
        end else begin
            init_word_s = s_mem[prev_idx_s] + q_r;
        end
        s_sum_s = s_mem[i_r] + a_r + b_r;
    end

    // B-side operands depend on the freshly rotated A'
    always_comb begin
        ab_sum_s = a_new_s + b_r;
        l_sum_s  = l_mem[j_r] + ab_sum_s;
        amt_s    = ab_sum_s[LGW-1:0];
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = INIT;
                else          state_s = IDLE;
            end
            INIT: begin
                if (last_init_s) state_s = MIX;
                else             state_s = INIT;
            end
            MIX: begin
                if (last_mix_s) state_s = DONE;
                else            state_s = MIX;
            end
            DONE: begin
                if (accept_s) state_s = INIT;
                else          state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, key arrays, mix registers and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            p_r     <= '0;
            q_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int n = 0; n < t; n++) s_mem[n] <= '0;
            for (int n = 0; n < c; n++) l_mem[n] <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                for (int n = 0; n < c; n++) l_mem[n] <= bus.l_in[n*w +: w];
                p_r    <= bus.pW;
                q_r    <= bus.qW;
                i_r    <= '0;
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end else begin
                // Status trails the state by one edge, so done rises at t+N+1
                busy_r <= (state_r == INIT) || (state_r == MIX);
                done_r <= (state_r == DONE);
                case (state_r)
                    INIT: begin
                        s_mem[i_r] <= init_word_s;
                        if (last_init_s) begin
                            a_r <= '0;
                            b_r <= '0;
                            i_r <= '0;
                            j_r <= '0;
                            k_r <= '0;
                        end else begin
                            i_r <= i_next_s;
                        end
                    end
                    MIX: begin
                        s_mem[i_r] <= a_new_s;
                        l_mem[j_r] <= b_new_s;
                        a_r        <= a_new_s;
                        b_r        <= b_new_s;
                        i_r        <= i_next_s;
                        j_r        <= j_next_s;
                        k_r        <= k_r + KW'(1);
                    end
                    default: begin
                        k_r <= k_r;
                    end
                endcase
            end
        end
    end

    // Registered S-table read port; out-of-range indices read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if ({1'b0, bus.rd_addr} < (IW + 1)'(t)) begin
            rd_data_r <= s_mem[bus.rd_addr];
        end else begin
            rd_data_r <= '0;
        end
    end

endmodule
